// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Feeds the per-digit seven-segment decoders from a core register value.
module bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    number,
  input  logic                signed_mode,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                negative,
  output logic                overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_next;
  logic [WIDTH-1:0] mag;
  logic [CW-1:0]    count;
  logic             pend_sign;
  logic             pend_ovf;
  logic             carry;
  logic             last;

  assign last = (count == CW'(WIDTH - 1));

  // Adjust every digit first, then shift the joined {digits, magnitude}.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    carry     = adj[BW-1];
    work_next = {adj[BW-2:0], mag[WIDTH-1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      mag       <= '0;
      count     <= '0;
      pend_sign <= 1'b0;
      pend_ovf  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (signed_mode && number[WIDTH-1]) begin
              mag       <= (~number) + WIDTH'(1);
              pend_sign <= 1'b1;
            end else begin
              mag       <= number;
              pend_sign <= 1'b0;
            end
            work     <= '0;
            pend_ovf <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work     <= work_next;
          mag      <= mag << 1;
          pend_ovf <= pend_ovf | carry;
          count    <= count + CW'(1);
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= work_next;
            negative <= pend_sign;
            overflow <= pend_ovf | carry;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: random and directed conversions
// checked against a decimal reference model.
module tb_bcd_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] number;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic        negative;
  logic        overflow;

  logic        s_start;
  logic [7:0]  s_number;
  logic        s_sm;
  logic        s_busy;
  logic        s_done;
  logic [7:0]  s_bcd;
  logic        s_neg;
  logic        s_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bcd_converter u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .number      (number),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .negative    (negative),
    .overflow    (overflow)
  );

  bcd_converter #(
    .WIDTH  (8),
    .DIGITS (2)
  ) u_small (
    .clock       (clock),
    .reset       (reset),
    .start       (s_start),
    .number      (s_number),
    .signed_mode (s_sm),
    .busy        (s_busy),
    .done        (s_done),
    .bcd         (s_bcd),
    .negative    (s_neg),
    .overflow    (s_ovf)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal digits by repeated division, truncated to nd digits.
  function automatic logic [63:0] ref_bcd(input logic [63:0] v,
                                          input int nd);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [63:0] v,
                                   input int nd);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return v >= p;
  endfunction

  task automatic run_big(input logic [31:0] num,
                         input logic sm,
                         input bit noise);
    int          n;
    bit          busy_ok;
    logic [63:0] mag;
    logic [63:0] eb;
    logic        en;
    logic        eo;
    en  = sm && num[31];
    mag = en ? (64'h1_0000_0000 - {32'd0, num}) : {32'd0, num};
    eb  = ref_bcd(mag, 10);
    eo  = ref_ovf(mag, 10);
    start       = 1'b1;
    number      = num;
    signed_mode = sm;
    @(posedge clock); #1;
    start       = 1'b0;
    number      = $urandom;
    signed_mode = 1'($urandom_range(0, 1));
    n       = 1;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (noise && n == 10) start = 1'b1;
      if (noise && n == 11) start = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    check("lat", 64'(n), 64'd33);
    check("busy_hi", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("bcd", 64'(bcd), eb);
    check("neg", 64'(negative), 64'(en));
    check("ovf", 64'(overflow), 64'(eo));
    @(posedge clock); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("bcd_hold", 64'(bcd), eb);
  endtask

  task automatic run_small(input logic [7:0] num);
    int n;
    s_start  = 1'b1;
    s_number = num;
    s_sm     = 1'b0;
    @(posedge clock); #1;
    s_start  = 1'b0;
    s_number = 8'($urandom);
    n = 1;
    while (!s_done && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("s_lat", 64'(n), 64'd9);
    check("s_bcd", 64'(s_bcd), ref_bcd(64'(num), 2));
    check("s_ovf", 64'(s_ovf), 64'(ref_ovf(64'(num), 2)));
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    int seen;
    reset       = 1'b1;
    start       = 1'b0;
    number      = '0;
    signed_mode = 1'b0;
    s_start     = 1'b0;
    s_number    = '0;
    s_sm        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_neg", 64'(negative), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_big(32'd0, 1'b0, 1'b0);
    run_big(32'hFFFF_FFFF, 1'b0, 1'b0);
    run_big(32'hFFFF_FFFF, 1'b1, 1'b0);
    run_big(32'h8000_0000, 1'b1, 1'b0);
    run_big(32'h0000_0000, 1'b1, 1'b1);
    run_big(32'h8000_0000, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i % 4 == 0) v = $urandom_range(0, 999);
      if (i % 4 == 1) v = -$urandom_range(1, 999);
      run_big(v, 1'($urandom_range(0, 1)), 1'(i % 2));
    end

    // Back-to-back: start held high through the DONE cycle.
    start       = 1'b1;
    number      = 32'd12345;
    signed_mode = 1'b0;
    @(posedge clock); #1;
    number = 32'd678;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("b2b_lat1", 64'(n), 64'd33);
    check("b2b_bcd1", 64'(bcd), 64'h12345);
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("b2b_lat2", 64'(n), 64'd33);
    check("b2b_bcd2", 64'(bcd), 64'h678);
    @(posedge clock); #1;

    // Reset in the middle of a conversion.
    start  = 1'b1;
    number = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_bcd", 64'(bcd), 64'd0);
    check("mid_neg", 64'(negative), 64'd0);
    check("mid_ovf", 64'(overflow), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(posedge clock); #1;
    end
    check("mid_quiet", 64'(seen), 64'd0);
    run_big(32'd42, 1'b0, 1'b0);

    run_small(8'd255);
    check("s_bcd255", 64'(s_bcd), 64'h55);
    check("s_ovf255", 64'(s_ovf), 64'd1);
    run_small(8'd99);
    check("s_bcd99", 64'(s_bcd), 64'h99);
    check("s_ovf99", 64'(s_ovf), 64'd0);
    for (int i = 0; i < 6; i++) run_small(8'($urandom_range(0, 255)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Sits between the integrated processor core and the seven-segment output stage.
- Takes a 32-bit register value from the core and produces packed decimal digits, which the per-digit seven-segment decoders consume.
- Uses one shift cycle per input bit and a start/busy/done handshake, so a single instance can be time-shared across the four output groups.

Parameters:
- WIDTH, 32, bit width of the binary operand.
- DIGITS, 10, number of BCD digits produced. 10 covers 2^32-1.

Ports:
- clock  input  1  system clock. Rising edge active.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of number. Sampled only when not busy.
- number  input  WIDTH  binary operand, captured on the accepted start cycle.
- signed_mode  input  1  1 = treat number as two's complement. Captured with number.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse marking that the result is valid.
- bcd  output  4*DIGITS  packed result. Digit 0 (units) is bcd[3:0]. Held until the next completion.
- negative  output  1  sign of the last completed result.
- overflow  output  1  last result exceeded DIGITS decimal digits.

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs):
  - state = IDLE.
  - busy = 0, done = 0, bcd = 0, negative = 0, overflow = 0.
  - Internal shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE / DONE with start = 1 (accepted cycle t):
  - Capture the operand.
  - If signed_mode = 1 and number[WIDTH-1] = 1: magnitude = (~number + 1) as unsigned WIDTH bits, and the pending sign is 1.
  - Otherwise: magnitude = number, and the pending sign is 0.
  - Clear the working BCD register, the pending overflow bit, and the bit counter.
  - Next state = SHIFT.
- SHIFT, each cycle, in order:
  1. Every working digit >= 5 gets +3.
  2. The combined {digits, magnitude} vector shifts left by 1.
  3. The bit leaving the top digit's MSB is ORed into pending overflow.
  4. The counter increments.
- SHIFT exit: after exactly WIDTH shift cycles, next state = DONE. On that transition, bcd, negative and overflow load from the working/pending values.
- DONE: done = 1 for exactly this one cycle.
  - Without start, next state = IDLE.
  - With start, the new operand is accepted (back-to-back, no idle bubble).
- Timing, start accepted in cycle t:
  - busy = 1 in cycles t+1 .. t+WIDTH.
  - done = 1 and the new bcd visible in cycle t+WIDTH+1.
  - Total latency is WIDTH+1 cycles.
- start while busy: ignored. The in-flight conversion is unaffected and no request is queued.
- number and signed_mode may change freely after the accepted cycle.
- bcd, negative and overflow change only on the SHIFT->DONE transition or reset. There are no intermediate values on the outputs.
- Most-negative signed input: 0x80000000 gives magnitude 2147483648 with no special case.
- Zero input: bcd = 0 and negative = 0. For signed zero, negative = 0.
- Truncation: when DIGITS is too small, overflow = 1 and bcd holds the value modulo 10^DIGITS. The lower digits are exact.
- Reset mid-conversion: abort at once, all outputs go to their reset values, and no done pulse is issued.
- busy and done are never high in the same cycle.

Test Plan:
- Reset, then unsigned start with number = 0:
  - busy high for 32 cycles.
  - done pulses at t+33.
  - bcd = 0, negative = 0, overflow = 0.
- Unsigned number = 0xFFFFFFFF: bcd = 40'h4294967295, negative = 0, overflow = 0.
- signed_mode = 1 inputs:
  - number = 0xFFFFFFFF -> bcd = 1, negative = 1.
  - number = 0x80000000 -> bcd = 40'h2147483648, negative = 1.
- Back-to-back conversions:
  - Start 12345 and hold start high through the DONE cycle with number = 678.
  - First done shows bcd = 40'h0000012345.
  - Second done comes 33 cycles later with bcd = 40'h0000000678.
  - A start pulse issued mid-conversion has no effect.
- Reset at cycle 10 of a 0xFFFFFFFF conversion:
  - All outputs read 0 on the next cycle and no done pulse follows.
  - A new start of 42 then gives bcd = 40'h42 after 33 cycles.
- Instance with WIDTH = 8, DIGITS = 2, number = 255 unsigned:
  - done at t+9.
  - bcd = 8'h55, overflow = 1.
  - A following conversion of 99 gives bcd = 8'h99 and overflow = 0.
